// File: rtl/shift_pkg.sv
// Shared types for the iterative shift sequencer:
// operation encodings and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_SHIFT = 2'b01,
    SEQ_DONE  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// One partial shift of a 32-bit value by 0..STEP bits.
// Purely combinational; feeds the sequencer work register.
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] val_i,
  input  logic [4:0]  step_i,
  input  sh_type_e    type_i,
  input  logic        fill_i,
  output logic [31:0] val_o
);

  logic [63:0] ext;

  // Select the shifted value for the latched operation type
  always_comb begin
    val_o = val_i;
    ext   = '0;
    unique case (type_i)
      SH_SLL: val_o = val_i << step_i;
      SH_SRL: val_o = val_i >> step_i;
      SH_SRA: begin
        ext   = {{32{fill_i}}, val_i} >> step_i;
        val_o = ext[31:0];
      end
      SH_ROR: begin
        ext   = {val_i, val_i} >> step_i;
        val_o = ext[31:0];
      end
      default: val_o = val_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter, at most STEP bits per cycle.
// Rotate (type 11) is built only with SHIFT_SEQ_ROR_EN.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic        out_illegal
);

  localparam logic [4:0] STEP_W = 5'(STEP);

`ifdef SHIFT_SEQ_ROR_EN
  localparam logic ROR_EN = 1'b1;
`else
  localparam logic ROR_EN = 1'b0;
`endif

  seq_state_e  state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] step_val;
  logic [4:0]  rem_q, rem_d;
  logic [4:0]  step;
  sh_type_e    type_q, type_d;
  logic        fill_q, fill_d;
  logic        ill_q, ill_d;
  logic        acc_ill;

  // Per-cycle step is min(rem, STEP); never underflows rem
  always_comb begin
    step    = (rem_q < STEP_W) ? rem_q : STEP_W;
    acc_ill = (sh_type_e'(in_type) == SH_ROR) && !ROR_EN;
  end

  shift_step u_step (
    .val_i  (work_q),
    .step_i (step),
    .type_i (type_q),
    .fill_i (fill_q),
    .val_o  (step_val)
  );

  // Next-state logic; flush beats accept and result handshake
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    type_d  = type_q;
    fill_d  = fill_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = SEQ_IDLE;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (in_valid) begin
            work_d  = in_a;
            rem_d   = in_shamt;
            type_d  = sh_type_e'(in_type);
            fill_d  = in_a[31];
            ill_d   = acc_ill;
            state_d = (in_shamt == 5'd0 || acc_ill)
                    ? SEQ_DONE : SEQ_SHIFT;
          end
        end
        SEQ_SHIFT: begin
          work_d = step_val;
          rem_d  = rem_q - step;
          if (rem_d == 5'd0) state_d = SEQ_DONE;
        end
        SEQ_DONE: begin
          if (out_ready) state_d = SEQ_IDLE;
        end
        default: state_d = SEQ_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      type_q  <= SH_SLL;
      fill_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      fill_q  <= fill_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready    = (state_q == SEQ_IDLE);
  assign out_valid   = (state_q == SEQ_DONE);
  assign out_r       = work_q;
  assign out_illegal = ill_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Iterative, handshaked controller for the processor's shift datapath.
- Accepts one shift operation (operand, 5-bit amount, 2-bit type), then performs it over several cycles, shifting at most `STEP` bit positions per cycle, and presents the 32-bit result on a valid/ready output.
- Sits between EX-stage issue and writeback as a small-area alternative to a single-cycle barrel shifter.
- Supports a pipeline flush that abandons the operation in flight.

## Interface
Parameters:
- `STEP`, default 4: maximum bit positions shifted per cycle; power of two, 1..16.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: abandon current operation; return to IDLE next edge.
- `in_valid`, input, 1: request carries a valid operation.
- `in_ready`, output, 1: sequencer can accept; high only in IDLE.
- `in_a`, input, 32: operand.
- `in_shamt`, input, 5: shift amount.
- `in_type`, input, 2: operation type.
  - 00 = SLL
  - 01 = SRL
  - 10 = SRA
  - 11 = ROR, or illegal when ROR is compiled out (see Configuration).
- `out_valid`, output, 1: result valid; high only in DONE.
- `out_ready`, input, 1: consumer takes the result.
- `out_r`, output, 32: result.
- `out_illegal`, output, 1: result came from an illegal type; qualified by `out_valid`.

## Operation
State machine with three states: IDLE, SHIFT, DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid` && !`flush`: latch `in_a` into the work register, plus type and remaining count `rem`=`in_shamt`.
  - If `in_shamt`==0, or the type is illegal: go to DONE.
  - Otherwise go to SHIFT.
- **SHIFT**
  - Each cycle: `step` = min(`rem`, `STEP`).
  - Work register shifted by `step` per the latched type:
    - SLL fills with 0.
    - SRL fills with 0.
    - SRA fills with the original bit 31.
    - ROR wraps the low bits to the top.
  - `rem` <= `rem` − `step`.
  - When the new `rem` is 0: go to DONE.
- **DONE**
  - `out_valid`=1; `out_r` = work register.
  - On `out_ready`: go to IDLE.
  - `out_r` and `out_illegal` hold stable while `out_valid`=1 and `out_ready`=0.
- **Flush**
  - `flush`=1 in any state: go to IDLE at the next edge; the result is discarded.
  - `flush` has priority over `in_valid` and over `out_ready`.
  - A flushed DONE result is never handshaken.
- **Arithmetic**
  - `rem` is 5 bits.
  - `step` is computed in 5 bits and never exceeds `rem`, so no underflow.
  - The SRA fill bit is sampled once, at accept.
- **Reset values**
  - State IDLE; `in_ready`=1.
  - `out_valid`=0, `out_r`=0, `out_illegal`=0.
  - Internal `rem`=0.
  - Reset asserted mid-operation aborts immediately and asynchronously; there is no partial output.

## Timing
- Accept at edge E0, when `in_valid`&&`in_ready`.
- Nonzero shift:
  - SHIFT occupies ceil(`shamt`/`STEP`) cycles.
  - `out_valid` rises at edge E0+ceil(`shamt`/`STEP`)+1.
- Zero shift or illegal type: `out_valid` rises at E0+1.
- Examples, `STEP`=4:
  - `shamt`=13 gives 4 SHIFT cycles (steps 4,4,4,1); `out_valid` at E0+5.
  - `shamt`=31 gives 8 SHIFT cycles.
- No accept in the same cycle as a DONE handshake. Minimum issue interval is (latency + 1) cycles.
- `in_ready` and `out_valid` are registered-state decodes; there is no combinational path from any input.

## Configuration
- Macro `SHIFT_SEQ_ROR_EN`.
- **Defined:** type 11 is rotate-right by `shamt`, sequenced like the other types; `out_illegal`=0.
- **Undefined:**
  - Type 11 is illegal: no shifting.
  - `out_r` = `in_a` unchanged; `out_illegal`=1.
  - Latency 1 cycle, regardless of `shamt`.

## Structure
- Shared package `shift_pkg`:
  - Type encodings `SH_SLL`, `SH_SRL`, `SH_SRA`, `SH_ROR`.
  - FSM state encoding `SEQ_IDLE`, `SEQ_SHIFT`, `SEQ_DONE`.
- One combinational sub-module, `shift_step`:
  - Inputs: 32-bit value, step 0..`STEP`, type, fill bit.
  - Output: shifted value.
  - Instantiated once, feeding the work register.

## Test plan
- `in_a`=0x0000_00F1, SLL, `shamt`=13, `STEP`=4 → `out_valid` at E0+5, `out_r`=0x001E_2000.
- `in_a`=0x8000_0010, SRA, `shamt`=31 → `out_r`=0xFFFF_FFFF after 8 SHIFT cycles; the same operand with SRL gives 0x0000_0001.
- `shamt`=0, SRL, `in_a`=0x1234_5678 → `out_valid` at E0+1, `out_r`=0x1234_5678.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_r`, `out_valid` stable and `in_ready`=0; release → IDLE next edge.
- `flush` during SHIFT cycle 2, with `in_valid` also high that cycle → IDLE, nothing accepted, no `out_valid`; `rst_n` low mid-SHIFT → all outputs at reset values immediately.
- Type 11, `in_a`=0x0000_000F, `shamt`=4:
  - With `SHIFT_SEQ_ROR_EN` → `out_r`=0xF000_0000, `out_illegal`=0.
  - Without → `out_r`=0x0000_000F, `out_illegal`=1, latency 1.
